// File: rtl/spi_master_cfg.sv
// SPI master with runtime CPOL/CPHA, bit order and transfer length, CS_N active-low selects,
// CS setup/hold measured in SCK half-periods, and a one-cycle done pulse.
module spi_master_cfg #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CS_N     = 2,
    parameter logic [31:0] DIV_COEF = 32'd100,
    parameter int unsigned CS_SETUP = 1,
    parameter int unsigned CS_HOLD  = 1,
    localparam int unsigned NB_W    = $clog2(DATA_W),
    localparam int unsigned CS_W    = (CS_N > 1) ? $clog2(CS_N) : 1
) (
    input  logic              clk_in,
    input  logic              nrst,
    input  logic              request,
    output logic              ready,
    output logic              done,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic [NB_W-1:0]   n_bits,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    output logic              spi_clk,
    output logic              spi_sdo,
    input  logic              spi_sdi,
    output logic [CS_N-1:0]   spi_cs
);
    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t            state_q, state_d;
    logic [31:0]       div_q, div_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
    logic [NB_W-1:0]   n_q, n_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic              clk_q, clk_d, sdo_q, sdo_d, ready_q, ready_d, done_q, done_d;
    logic [CS_N-1:0]   cs_q, cs_d;

    logic              tick, leading, last_tog;
    logic [31:0]       tog;
    logic [NB_W-1:0]   bit_k;

    function automatic logic [NB_W-1:0] bit_pos(input logic [NB_W-1:0] k,
                                                input logic [NB_W-1:0] n,
                                                input logic            lsb);
        return lsb ? k : n - k;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        dout_d   = dout_q;
        n_d      = n_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        lsb_d    = lsb_q;
        clk_d    = clk_q;
        sdo_d    = sdo_q;
        cs_d     = cs_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
        tick     = (div_q == DIV_COEF - 32'd1);
        tog      = cnt_q + 32'd1;
        leading  = tog[0];
        last_tog = (tog == ((32'(n_q) + 32'd1) << 1));
        bit_k    = NB_W'(cnt_q >> 1);
        div_d    = (state_q == IDLE || tick) ? '0 : div_q + 32'd1;

        case (state_q)
            IDLE: begin
                clk_d   = cpol;
                ready_d = 1'b1;
                cs_d    = '1;
                if (request && (32'(cs_sel) < CS_N)) begin
                    state_d = SETUP;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    tx_d    = data_in;
                    rx_d    = '0;
                    n_d     = n_bits;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsb_d   = lsb_first;
                    cs_d    = ~(CS_N'(1) << cs_sel);
                    if (!cpha) sdo_d = data_in[bit_pos(NB_W'(0), n_bits, lsb_first)];
                end
            end
            SETUP: begin
                clk_d = cpol_q;
                if (tick) begin
                    if (cnt_q + 32'd1 == CS_SETUP) begin
                        state_d = XFER;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            XFER: begin
                if (tick) begin
                    clk_d = ~clk_q;
                    cnt_d = tog;
                    // sample edge is leading for cpha=0, trailing for cpha=1
                    if (leading ^ cpha_q) rx_d[bit_pos(bit_k, n_q, lsb_q)] = spi_sdi;
                    if (cpha_q && leading)
                        sdo_d = tx_q[bit_pos(bit_k, n_q, lsb_q)];
                    else if (!cpha_q && !leading && !last_tog)
                        sdo_d = tx_q[bit_pos(bit_k + NB_W'(1), n_q, lsb_q)];
                    if (last_tog) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                end
            end
            HOLD: begin
                clk_d = cpol_q;
                if (tick) begin
                    if (cnt_q + 32'd1 == CS_HOLD) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        cs_d    = '1;
                        dout_d  = rx_q;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            n_q     <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            clk_q   <= 1'b0;
            sdo_q   <= 1'b0;
            cs_q    <= '1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            n_q     <= n_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            clk_q   <= clk_d;
            sdo_q   <= sdo_d;
            cs_q    <= cs_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign data_out = dout_q;
    assign spi_clk  = clk_q;
    assign spi_sdo  = sdo_q;
    assign spi_cs   = cs_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: a behavioural SPI slave/observer and a word-level model of
// bit order, received data and done latency.
module tb_spi_master_cfg;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CS_N   = 2;
    localparam int unsigned DIV    = 4;
    localparam int unsigned SETUP  = 1;
    localparam int unsigned HOLD   = 1;

    logic        clk_in = 1'b0, nrst = 1'b0, request = 1'b0, request3 = 1'b0;
    logic        cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0, sdi_drv = 1'b0, loopback = 1'b0;
    logic [31:0] data_in = '0;
    logic [4:0]  n_bits = '0;
    logic [0:0]  cs_sel = '0;
    logic [1:0]  cs_sel3 = '0;
    logic        ready, done, spi_clk, spi_sdo, spi_sdi;
    logic [31:0] data_out;
    logic [1:0]  spi_cs;
    logic        ready3, done3, spi_clk3, spi_sdo3;
    logic [31:0] data_out3;
    logic [2:0]  spi_cs3;

    int unsigned checks = 0, failures = 0;

    int unsigned obs_toggles, obs_lat, obs_done_cnt, obs_nsamp;
    logic [31:0] obs_sdo_word, obs_dout;
    logic [1:0]  obs_cs1;
    logic        obs_other_low, obs_sel_bad, obs_ready1, obs_busy_after, obs_clk_pre, obs_clk_post;

    assign spi_sdi = loopback ? spi_sdo : sdi_drv;

    always #5 clk_in = ~clk_in;

    spi_master_cfg #(.DATA_W(DATA_W), .CS_N(CS_N), .DIV_COEF(32'd4), .CS_SETUP(SETUP), .CS_HOLD(HOLD)) dut (
        .clk_in(clk_in), .nrst(nrst), .request(request), .ready(ready), .done(done),
        .data_in(data_in), .data_out(data_out), .n_bits(n_bits), .cs_sel(cs_sel),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .spi_clk(spi_clk),
        .spi_sdo(spi_sdo), .spi_sdi(spi_sdi), .spi_cs(spi_cs)
    );

    // three selects need a 2-bit cs_sel, so an out-of-range index can be expressed
    spi_master_cfg #(.DATA_W(DATA_W), .CS_N(3), .DIV_COEF(32'd4), .CS_SETUP(SETUP), .CS_HOLD(HOLD)) u_cs3 (
        .clk_in(clk_in), .nrst(nrst), .request(request3), .ready(ready3), .done(done3),
        .data_in(data_in), .data_out(data_out3), .n_bits(n_bits), .cs_sel(cs_sel3),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .spi_clk(spi_clk3),
        .spi_sdo(spi_sdo3), .spi_sdi(spi_sdi), .spi_cs(spi_cs3)
    );

    function automatic logic [31:0] mask_of(input int unsigned n);
        logic [63:0] m;
        m = (64'd1 << (n + 1)) - 64'd1;
        return m[31:0];
    endfunction

    // reverse the low n+1 bits of w
    function automatic logic [31:0] rev_low(input logic [31:0] w, input int unsigned n);
        logic [31:0] r;
        r = {<<{w}};
        return r >> (31 - n);
    endfunction

    // serial MOSI stream packed first-bit-in-MSB of an (n+1)-bit field
    function automatic logic [31:0] exp_sent(input logic [31:0] d, input int unsigned n, input logic lsb);
        return lsb ? rev_low(d, n) : (d & mask_of(n));
    endfunction

    // slave sends bit k of s as its k-th bit
    function automatic logic [31:0] exp_rx(input logic [31:0] s, input int unsigned n, input logic lsb);
        return lsb ? (s & mask_of(n)) : rev_low(s, n);
    endfunction

    function automatic int unsigned exp_lat(input int unsigned n);
        return 1 + (SETUP + 2 * (n + 1) + HOLD) * DIV;
    endfunction

    task automatic do_xfer(input logic [31:0] d, input int unsigned n, input int unsigned sel,
                           input logic cp, input logic ph, input logic lsb,
                           input logic [31:0] sword, input int unsigned mid_req);
        int unsigned cyc = 0;
        int unsigned post = 0;
        logic        prev_clk;
        logic        seen = 1'b0;
        @(negedge clk_in);
        data_in = d; n_bits = 5'(n); cs_sel = 1'(sel);
        cpol = cp; cpha = ph; lsb_first = lsb; sdi_drv = sword[0];
        obs_toggles = 0; obs_lat = 0; obs_done_cnt = 0; obs_nsamp = 0;
        obs_sdo_word = '0; obs_dout = '0; obs_cs1 = '0;
        obs_other_low = 1'b0; obs_sel_bad = 1'b0; obs_ready1 = 1'b1; obs_busy_after = 1'b0;
        repeat (2) @(negedge clk_in);
        obs_clk_pre = spi_clk;
        prev_clk    = spi_clk;
        request     = 1'b1;
        @(posedge clk_in);
        while (post < 4 && cyc < 5000) begin
            @(negedge clk_in);
            cyc++;
            if (cyc == 1) begin
                request = 1'b0;
                obs_ready1 = ready;
                obs_cs1 = spi_cs;
                data_in = ~d; n_bits = ~n_bits; cpha = ~ph; lsb_first = ~lsb; cs_sel = ~cs_sel;
            end
            if (mid_req != 0 && cyc == mid_req) request = 1'b1;
            if (mid_req != 0 && cyc == mid_req + 1) request = 1'b0;
            if (spi_clk !== prev_clk) begin
                obs_toggles++;
                prev_clk = spi_clk;
                if (((obs_toggles % 2) == 1) == (ph == 1'b0)) begin
                    obs_sdo_word = {obs_sdo_word[30:0], spi_sdo};
                    if (spi_cs[sel] !== 1'b0) obs_sel_bad = 1'b1;
                    obs_nsamp++;
                    if (obs_nsamp < 32) sdi_drv = sword[obs_nsamp];
                end
            end
            for (int unsigned i = 0; i < CS_N; i++)
                if (i != sel && spi_cs[i] !== 1'b1) obs_other_low = 1'b1;
            if (done === 1'b1) begin
                obs_done_cnt++;
                if (!seen) begin
                    seen = 1'b1;
                    obs_lat = cyc;
                    obs_dout = data_out;
                end
            end
            if (seen) begin
                post++;
                if (post > 1 && ready !== 1'b1) obs_busy_after = 1'b1;
            end
        end
        request = 1'b0;
        obs_clk_post = spi_clk;
    endtask

    task automatic test_reset();
        nrst = 1'b0; request = 1'b1; data_in = $urandom; cs_sel = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++; if (spi_cs !== 2'b11) begin failures++; $display("FAIL reset_cs: got %b want 11", spi_cs); end
        checks++; if (spi_clk !== 1'b0) begin failures++; $display("FAIL reset_clk: got %b want 0", spi_clk); end
        checks++; if (spi_sdo !== 1'b0) begin failures++; $display("FAIL reset_sdo: got %b want 0", spi_sdo); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL reset_dout: got %h want 0", data_out); end
        request = 1'b0;
        @(negedge clk_in);
        nrst = 1'b1;
        repeat (3) @(negedge clk_in);
        checks++; if (spi_cs !== 2'b11 || ready !== 1'b1) begin
            failures++; $display("FAIL reset_release: cs=%b ready=%b want cs=11 ready=1", spi_cs, ready);
        end
    endtask

    task automatic test_mode0_msb();
        do_xfer(32'h8F00, 15, 0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 0);
        checks++; if (obs_sdo_word !== 32'h8F00) begin failures++; $display("FAIL m0_sdo_seq: got %h want 8f00", obs_sdo_word); end
        checks++; if (obs_lat !== 137) begin failures++; $display("FAIL m0_latency: got %0d want 137", obs_lat); end
        checks++; if (obs_dout !== 32'h0000FFFF) begin failures++; $display("FAIL m0_dout: got %h want 0000ffff", obs_dout); end
        checks++; if (obs_toggles !== 32) begin failures++; $display("FAIL m0_toggles: got %0d want 32", obs_toggles); end
        checks++; if (obs_ready1 !== 1'b0 || obs_cs1 !== 2'b10) begin
            failures++; $display("FAIL m0_accept: ready=%b cs=%b want ready=0 cs=10", obs_ready1, obs_cs1);
        end
        checks++; if (obs_other_low !== 1'b0 || obs_sel_bad !== 1'b0) begin
            failures++; $display("FAIL m0_cs: other_low=%b sel_high=%b want 0 0", obs_other_low, obs_sel_bad);
        end
        checks++; if (obs_done_cnt !== 1) begin failures++; $display("FAIL m0_done_cnt: got %0d want 1", obs_done_cnt); end
    endtask

    task automatic test_mode3_lsb_loop();
        loopback = 1'b1;
        do_xfer(32'hA5, 7, 1, 1'b1, 1'b1, 1'b1, 32'h0, 0);
        loopback = 1'b0;
        checks++; if (obs_clk_pre !== 1'b1 || obs_clk_post !== 1'b1) begin
            failures++; $display("FAIL m3_idle_clk: pre=%b post=%b want 1 1", obs_clk_pre, obs_clk_post);
        end
        checks++; if (obs_sdo_word !== exp_sent(32'hA5, 7, 1'b1) || obs_sdo_word !== 32'hA5) begin
            failures++; $display("FAIL m3_sdo_seq: got %h want a5", obs_sdo_word);
        end
        checks++; if (obs_dout !== 32'h000000A5) begin failures++; $display("FAIL m3_dout: got %h want 000000a5", obs_dout); end
        checks++; if (obs_cs1 !== 2'b01 || obs_other_low !== 1'b0) begin
            failures++; $display("FAIL m3_cs: cs=%b other_low=%b want 01 0", obs_cs1, obs_other_low);
        end
        checks++; if (obs_lat !== exp_lat(7)) begin failures++; $display("FAIL m3_latency: got %0d want %0d", obs_lat, exp_lat(7)); end
    endtask

    task automatic test_one_bit();
        do_xfer(32'h1, 0, 0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 0);
        checks++; if (obs_toggles !== 2) begin failures++; $display("FAIL onebit_toggles: got %0d want 2", obs_toggles); end
        checks++; if (obs_dout !== 32'h1) begin failures++; $display("FAIL onebit_dout: got %h want 1", obs_dout); end
        checks++; if (obs_lat !== 1 + 4 * DIV) begin failures++; $display("FAIL onebit_latency: got %0d want %0d", obs_lat, 1 + 4 * DIV); end
        checks++; if (obs_sdo_word !== 32'h1) begin failures++; $display("FAIL onebit_sdo: got %h want 1", obs_sdo_word); end
    endtask

    task automatic test_mid_request();
        logic [31:0] d, s;
        d = $urandom; s = $urandom | 32'h1;
        do_xfer(d, 15, 0, 1'b0, 1'b0, 1'b0, s, 40);
        checks++; if (obs_done_cnt !== 1 || obs_busy_after !== 1'b0) begin
            failures++; $display("FAIL midreq_ignored: done_cnt=%0d busy_after=%b want 1 0", obs_done_cnt, obs_busy_after);
        end
        checks++; if (obs_lat !== exp_lat(15)) begin failures++; $display("FAIL midreq_latency: got %0d want %0d", obs_lat, exp_lat(15)); end
        checks++; if (obs_dout !== exp_rx(s, 15, 1'b0)) begin
            failures++; $display("FAIL midreq_dout: got %h want %h", obs_dout, exp_rx(s, 15, 1'b0));
        end
    endtask

    task automatic test_bad_cs();
        logic clk0, sdo0;
        logic bad_ready = 1'b0, bad_cs = 1'b0, bad_pin = 1'b0, bad_done = 1'b0;
        @(negedge clk_in);
        clk0 = spi_clk3; sdo0 = spi_sdo3;
        cs_sel3 = 2'd3; request3 = 1'b1;
        repeat (20) begin
            @(negedge clk_in);
            if (ready3 !== 1'b1) bad_ready = 1'b1;
            if (spi_cs3 !== 3'b111) bad_cs = 1'b1;
            if (spi_clk3 !== clk0 || spi_sdo3 !== sdo0) bad_pin = 1'b1;
            if (done3 !== 1'b0) bad_done = 1'b1;
        end
        request3 = 1'b0;
        checks++; if (bad_ready) begin failures++; $display("FAIL badcs_ready: ready dropped, want held 1"); end
        checks++; if (bad_cs) begin failures++; $display("FAIL badcs_cs: a select went low, want 111"); end
        checks++; if (bad_pin) begin failures++; $display("FAIL badcs_pins: sck/sdo moved, want %b/%b", clk0, sdo0); end
        checks++; if (bad_done) begin failures++; $display("FAIL badcs_done: done pulsed, want 0"); end
    endtask

    task automatic test_reset_mid();
        logic        done_seen = 1'b0;
        logic [31:0] d, s;
        @(negedge clk_in);
        cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; n_bits = 5'd15; cs_sel = 1'b0; data_in = $urandom;
        repeat (2) @(negedge clk_in);
        request = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        request = 1'b0;
        repeat (67) @(negedge clk_in);
        checks++; if (spi_cs !== 2'b10) begin failures++; $display("FAIL rstmid_busy: cs=%b want 10", spi_cs); end
        #2 nrst = 1'b0;
        #1;
        checks++; if (spi_cs !== 2'b11 || spi_clk !== 1'b0 || spi_sdo !== 1'b0) begin
            failures++; $display("FAIL rstmid_pins: cs=%b clk=%b sdo=%b want 11 0 0", spi_cs, spi_clk, spi_sdo);
        end
        checks++; if (ready !== 1'b1 || done !== 1'b0 || data_out !== 32'h0) begin
            failures++; $display("FAIL rstmid_outs: ready=%b done=%b dout=%h want 1 0 0", ready, done, data_out);
        end
        repeat (4) begin
            @(negedge clk_in);
            if (done !== 1'b0) done_seen = 1'b1;
        end
        nrst = 1'b1;
        repeat (4) begin
            @(negedge clk_in);
            if (done !== 1'b0) done_seen = 1'b1;
        end
        checks++; if (done_seen) begin failures++; $display("FAIL rstmid_nodone: done pulsed, want none"); end
        d = $urandom; s = $urandom;
        do_xfer(d, 15, 0, 1'b1, 1'b0, 1'b0, s, 0);
        checks++; if (obs_dout !== exp_rx(s, 15, 1'b0) || obs_lat !== exp_lat(15) || obs_done_cnt !== 1) begin
            failures++; $display("FAIL rstmid_fresh: dout=%h lat=%0d dn=%0d want %h %0d 1",
                                 obs_dout, obs_lat, obs_done_cnt, exp_rx(s, 15, 1'b0), exp_lat(15));
        end
    endtask

    task automatic test_random();
        for (int unsigned it = 0; it < 12; it++) begin
            logic [31:0]  d, s;
            int unsigned  n, sel;
            logic         cp, ph, lsb;
            d = $urandom; s = $urandom;
            n = $urandom_range(0, 31); sel = $urandom_range(0, 1);
            cp = 1'($urandom); ph = 1'($urandom); lsb = 1'($urandom);
            do_xfer(d, n, sel, cp, ph, lsb, s, 0);
            checks++; if (obs_dout !== exp_rx(s, n, lsb)) begin
                failures++; $display("FAIL rand%0d_dout: got %h want %h (n=%0d mode=%b%b lsb=%b)",
                                     it, obs_dout, exp_rx(s, n, lsb), n, cp, ph, lsb);
            end
            checks++; if (obs_sdo_word !== exp_sent(d, n, lsb)) begin
                failures++; $display("FAIL rand%0d_sdo: got %h want %h", it, obs_sdo_word, exp_sent(d, n, lsb));
            end
            checks++; if (obs_lat !== exp_lat(n) || obs_done_cnt !== 1) begin
                failures++; $display("FAIL rand%0d_timing: lat=%0d dn=%0d want %0d 1", it, obs_lat, obs_done_cnt, exp_lat(n));
            end
            checks++; if (obs_toggles !== 2 * (n + 1) || obs_clk_pre !== cp || obs_clk_post !== cp) begin
                failures++; $display("FAIL rand%0d_sck: toggles=%0d pre=%b post=%b want %0d %b %b",
                                     it, obs_toggles, obs_clk_pre, obs_clk_post, 2 * (n + 1), cp, cp);
            end
            checks++; if (obs_other_low !== 1'b0 || obs_sel_bad !== 1'b0) begin
                failures++; $display("FAIL rand%0d_cs: other_low=%b sel_high=%b want 0 0", it, obs_other_low, obs_sel_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode0_msb();
        test_mode3_lsb_loop();
        test_one_bit();
        test_mid_request();
        test_bad_cs();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
